as_wb_master_ctrl: RTL and testbench

AS_WB_MASTER_CTRL -- requirements
Module: as_wb_master_ctrl

---
 rtl/as_wb_master_ctrl.sv | 158 +++++++++++++++
 tb/tb_as_wb_master_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/as_wb_master_ctrl.sv
// Single-beat Wishbone master: turns a core load/store request into one bus
// cycle with lane steering, load extension, misalignment trap and ack timeout.
module as_wb_master_ctrl #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [ADDR_W-1:0]     wb_m_addr_o,
  output logic [DATA_W-1:0]     wb_m_dat_o,
  input  logic [DATA_W-1:0]     wb_m_dat_i,
  output logic                  wb_m_we_o,
  output logic [DATA_W/8-1:0]   wb_m_sel_o,
  output logic                  wb_m_stb_o,
  output logic                  wb_m_cyc_o,
  input  logic                  wb_m_ack_i,
  input  logic                  wb_m_err_i
);
  localparam int NSEL  = DATA_W / 8;
  localparam int OFF_W = $clog2(NSEL);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  typedef struct packed {
    logic [OFF_W-1:0] off;
    logic [1:0]       size;
    logic             uns;
  } req_t;

  state_t              r_state, w_next;
  req_t                r_req;
  logic [7:0]          r_cnt;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_dat;
  logic [NSEL-1:0]     r_sel;
  logic                r_we;

  logic                w_accept, w_mis, w_resp, w_tmo;
  logic [NSEL-1:0]     w_sel_base, w_sel;
  logic [2:0]          w_lmask;
  logic [DATA_W-1:0]   w_dat;
  logic [63:0]         w_sh, w_ld64;
  logic [DATA_W-1:0]   w_ld;

  assign w_accept = ~rst_i & req_i & (r_state != BUS);
  assign w_resp   = (r_state == BUS) & (wb_m_ack_i | wb_m_err_i);
  assign w_tmo    = (r_state == BUS) & ~(wb_m_ack_i | wb_m_err_i) & (r_cnt == TMO_LAST);

  // request decode: alignment, lane selects and replicated store data
  always_comb begin
    w_mis      = 1'b0;
    w_sel_base = '0;
    w_lmask    = 3'd0;
    case (size_i)
      2'd0: begin w_sel_base = NSEL'(8'h01); w_lmask = 3'd0; end
      2'd1: begin w_sel_base = NSEL'(8'h03); w_lmask = 3'd1; w_mis = addr_i[0]; end
      2'd2: begin w_sel_base = NSEL'(8'h0F); w_lmask = 3'd3; w_mis = |addr_i[1:0]; end
      default: begin
        w_sel_base = NSEL'(8'hFF);
        w_lmask    = 3'd7;
        w_mis      = (|addr_i[2:0]) | (DATA_W == 32);
      end
    endcase
    w_sel = w_sel_base << addr_i[OFF_W-1:0];
    w_dat = '0;
    for (int b = 0; b < NSEL; b++)
      w_dat[8*b +: 8] = wdata_i[8*(b & int'(w_lmask)) +: 8];
  end

  // load path: shift the addressed bytes down, then extend from the access width
  always_comb begin
    w_sh   = 64'(wb_m_dat_i >> {r_req.off, 3'b000});
    w_ld64 = w_sh;
    case (r_req.size)
      2'd0:    w_ld64 = {{56{~r_req.uns & w_sh[7]}},  w_sh[7:0]};
      2'd1:    w_ld64 = {{48{~r_req.uns & w_sh[15]}}, w_sh[15:0]};
      2'd2:    w_ld64 = {{32{~r_req.uns & w_sh[31]}}, w_sh[31:0]};
      default: w_ld64 = w_sh;
    endcase
    w_ld = w_ld64[DATA_W-1:0];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, RESP: begin
        w_next = IDLE;
        if (w_accept) w_next = w_mis ? RESP : BUS;
      end
      BUS:     if (w_resp || w_tmo) w_next = RESP;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_err <= w_mis;
        r_cnt <= '0;
        // a trapped access leaves the bus registers untouched; stb stays low anyway
        if (!w_mis) begin
          r_req.off  <= addr_i[OFF_W-1:0];
          r_req.size <= size_i;
          r_req.uns  <= unsigned_i;
          r_addr     <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          r_dat      <= w_dat;
          r_sel      <= w_sel;
          r_we       <= we_i;
        end
      end else if (r_state == BUS) begin
        if (w_resp) begin
          r_err <= wb_m_err_i;
          if (!wb_m_err_i && !r_we) r_rdata <= w_ld;
        end else if (w_tmo) begin
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  assign busy_o      = (r_state == BUS) | w_accept;
  assign done_o      = (r_state == RESP);
  assign err_o       = (r_state == RESP) & r_err;
  assign rdata_o     = r_rdata;
  assign wb_m_cyc_o  = (r_state == BUS);
  assign wb_m_stb_o  = (r_state == BUS);
  assign wb_m_addr_o = r_addr;
  assign wb_m_dat_o  = r_dat;
  assign wb_m_sel_o  = r_sel;
  assign wb_m_we_o   = r_we;
endmodule

// File: tb/tb_as_wb_master_ctrl.sv
// Directed bench: a transaction-level model sets per-cycle expectations that one
// negedge process compares; literal checks pin latency, lanes and load results.
module tb_as_wb_master_ctrl;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst_i, req_i, we_i, unsigned_i;
  logic [AW-1:0] addr_i;
  logic [1:0]    size_i;
  logic [DW-1:0] wdata_i, wb_m_dat_i;
  logic          wb_m_ack_i, wb_m_err_i;
  logic          busy_o, done_o, err_o, wb_m_we_o, wb_m_stb_o, wb_m_cyc_o;
  logic [DW-1:0] rdata_o, wb_m_dat_o;
  logic [AW-1:0] wb_m_addr_o;
  logic [7:0]    wb_m_sel_o;

  as_wb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .size_i(size_i), .unsigned_i(unsigned_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .wb_m_addr_o(wb_m_addr_o), .wb_m_dat_o(wb_m_dat_o), .wb_m_dat_i(wb_m_dat_i),
    .wb_m_we_o(wb_m_we_o), .wb_m_sel_o(wb_m_sel_o), .wb_m_stb_o(wb_m_stb_o),
    .wb_m_cyc_o(wb_m_cyc_o), .wb_m_ack_i(wb_m_ack_i), .wb_m_err_i(wb_m_err_i));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic chk_en = 1'b0;
  logic exp_busy = 0, exp_done = 0, exp_err = 0, exp_stb = 0, exp_we = 0;
  logic [DW-1:0] exp_rdata = '0, exp_dat = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [7:0]    exp_sel = '0;
  int cyc_idx = 0, obs_stb_cnt = 0, obs_done_at = -1;
  logic obs_err = 0;
  logic [7:0]    obs_sel = '0;
  logic [AW-1:0] obs_addr = '0;
  logic [DW-1:0] obs_dat = '0;
  logic          obs_we = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] m_sel(input logic [AW-1:0] a, input logic [1:0] sz);
    int n = 1 << sz;
    int s = ((1 << n) - 1) << (a % 8);
    return s[7:0];
  endfunction

  function automatic logic [DW-1:0] m_dat(input logic [DW-1:0] wd, input logic [1:0] sz);
    logic [DW-1:0] d;
    int n = 1 << sz;
    for (int b = 0; b < 8; b++) d[8*b +: 8] = wd[8*(b % n) +: 8];
    return d;
  endfunction

  function automatic logic [DW-1:0] m_ld(input logic [DW-1:0] din, input logic [AW-1:0] a,
                                         input logic [1:0] sz, input logic uns);
    logic [63:0] v = din >> (8 * (a % 8));
    logic [63:0] mask;
    int n = 1 << sz;
    if (n < 8) begin
      mask = (64'd1 << (8 * n)) - 64'd1;
      v = v & mask;
      if (!uns && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {63'd0, busy_o}, {63'd0, exp_busy});
      chk("done", {63'd0, done_o}, {63'd0, exp_done});
      chk("stb",  {63'd0, wb_m_stb_o}, {63'd0, exp_stb});
      chk("cyc",  {63'd0, wb_m_cyc_o}, {63'd0, exp_stb});
      chk("rdata", rdata_o, exp_rdata);
      if (exp_done) chk("err", {63'd0, err_o}, {63'd0, exp_err});
      if (exp_stb) begin
        chk("bus_addr", wb_m_addr_o, exp_addr);
        chk("bus_sel", {56'd0, wb_m_sel_o}, {56'd0, exp_sel});
        chk("bus_dat", wb_m_dat_o, exp_dat);
        chk("bus_we", {63'd0, wb_m_we_o}, {63'd0, exp_we});
      end
    end
    if (wb_m_stb_o) begin
      obs_stb_cnt++;
      obs_sel = wb_m_sel_o; obs_addr = wb_m_addr_o; obs_dat = wb_m_dat_o; obs_we = wb_m_we_o;
    end
    if (done_o) begin obs_done_at = cyc_idx; obs_err = err_o; end
    cyc_idx++;
  end

  // delay: wait cycles before the slave answers; -1 means the slave never answers
  task automatic run_txn(input logic we, input logic [AW-1:0] a, input logic [1:0] sz,
                         input logic uns, input logic [DW-1:0] wd, input int delay,
                         input logic ack_v, input logic err_v, input logic [DW-1:0] din);
    logic mis = (a % (64'd1 << sz)) != 0;
    int   last = (delay < 0) ? TMO : delay + 1;
    step();
    req_i = 1; we_i = we; addr_i = a; size_i = sz; unsigned_i = uns; wdata_i = wd;
    cyc_idx = 0; obs_stb_cnt = 0; obs_done_at = -1; obs_err = 0;
    exp_busy = 1; exp_stb = 0; exp_done = 0;
    step();
    req_i = 0;
    if (mis) begin
      exp_busy = 0; exp_done = 1; exp_err = 1;
    end else begin
      exp_addr = a & ~64'd7; exp_sel = m_sel(a, sz); exp_dat = m_dat(wd, sz); exp_we = we;
      for (int c = 1; c <= last; c++) begin
        exp_busy = 1; exp_stb = 1;
        if (c == delay + 1) begin wb_m_ack_i = ack_v; wb_m_err_i = err_v; wb_m_dat_i = din; end
        else begin wb_m_ack_i = 0; wb_m_err_i = 0; wb_m_dat_i = ~din; end
        step();
      end
      wb_m_ack_i = 0; wb_m_err_i = 0;
      exp_stb = 0; exp_busy = 0; exp_done = 1;
      exp_err = (delay < 0) | err_v;
      if (!we && delay >= 0 && !err_v) exp_rdata = m_ld(din, a, sz, uns);
    end
    step();
    exp_done = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_i = 1; req_i = 0; we_i = 0; addr_i = '0; size_i = '0; unsigned_i = 0;
    wdata_i = '0; wb_m_dat_i = '0; wb_m_ack_i = 0; wb_m_err_i = 0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_err",  {63'd0, err_o}, 64'd0);
    chk("rst_rdata", rdata_o, 64'd0);
    chk("rst_cycstb", {62'd0, wb_m_cyc_o, wb_m_stb_o}, 64'd0);
    chk("rst_we_sel", {55'd0, wb_m_we_o, wb_m_sel_o}, 64'd0);
    chk("rst_addr", wb_m_addr_o, 64'd0);
    chk("rst_dat", wb_m_dat_o, 64'd0);
    step();
    rst_i = 0; chk_en = 1;

    // signed byte load, ack at cycle 3
    run_txn(0, 64'h1003, 2'd0, 0, '0, 2, 1, 0, 64'h0000_0000_8000_0000);
    chk("lb_sel", {56'd0, obs_sel}, 64'h08);
    chk("lb_addr", obs_addr, 64'h1000);
    chk("lb_done_at", 64'(obs_done_at), 64'd4);
    chk("lb_rdata", rdata_o, 64'hFFFF_FFFF_FFFF_FF80);

    // ack and err together: err wins, rdata kept
    run_txn(0, 64'h1000, 2'd3, 1, '0, 0, 1, 1, 64'h1234_5678_9ABC_DEF0);
    chk("ackerr_err", {63'd0, obs_err}, 64'd1);
    chk("ackerr_rdata", rdata_o, 64'hFFFF_FFFF_FFFF_FF80);

    // halfword store, zero-wait
    run_txn(1, 64'h2006, 2'd1, 0, 64'h0000_0000_0000_ABCD, 0, 1, 0, '0);
    chk("sh_sel", {56'd0, obs_sel}, 64'hC0);
    chk("sh_dat", obs_dat, 64'hABCD_ABCD_ABCD_ABCD);
    chk("sh_we", {63'd0, obs_we}, 64'd1);
    chk("sh_done_at", 64'(obs_done_at), 64'd2);
    chk("sh_err", {63'd0, obs_err}, 64'd0);

    // misaligned word load: no strobe, trap at cycle 1
    run_txn(0, 64'h2002, 2'd2, 0, '0, 0, 1, 0, '0);
    chk("mis_stb_cnt", 64'(obs_stb_cnt), 64'd0);
    chk("mis_done_at", 64'(obs_done_at), 64'd1);
    chk("mis_err", {63'd0, obs_err}, 64'd1);

    // silent slave: timeout
    run_txn(0, 64'h3000, 2'd3, 0, '0, -1, 0, 0, '0);
    chk("tmo_stb_cnt", 64'(obs_stb_cnt), 64'd4);
    chk("tmo_done_at", 64'(obs_done_at), 64'd5);
    chk("tmo_err", {63'd0, obs_err}, 64'd1);

    // ack on the last wait cycle beats the timeout
    run_txn(0, 64'h4006, 2'd1, 1, '0, 3, 1, 0, 64'hBEEF_0000_0000_0000);
    chk("late_ack_err", {63'd0, obs_err}, 64'd0);
    chk("lhu_rdata", rdata_o, 64'h0000_0000_0000_BEEF);

    run_txn(0, 64'h4004, 2'd2, 0, '0, 1, 1, 0, 64'h8765_4321_0000_0000);
    chk("lw_rdata", rdata_o, 64'hFFFF_FFFF_8765_4321);
    run_txn(1, 64'h5005, 2'd0, 0, 64'h0000_0000_0000_005A, 1, 1, 0, '0);
    chk("sb_sel", {56'd0, obs_sel}, 64'h20);
    run_txn(0, 64'h4004, 2'd3, 0, '0, 0, 1, 0, '0);
    run_txn(0, 64'h4008, 2'd3, 0, '0, 1, 1, 0, 64'h0102_0304_0506_0708);

    // back-to-back with ack held high (also covers ack ignored outside BUS)
    step();
    req_i = 1; we_i = 0; addr_i = 64'h6000; size_i = 2'd3; unsigned_i = 1; wdata_i = '0;
    wb_m_dat_i = 64'h1122_3344_5566_7788; wb_m_ack_i = 1; wb_m_err_i = 0;
    exp_addr = 64'h6000; exp_sel = 8'hFF; exp_dat = '0; exp_we = 0; exp_err = 0;
    cyc_idx = 0; obs_stb_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      exp_busy = 1;
      exp_stb  = (c % 2) == 1;
      exp_done = (c >= 2) && (c % 2 == 0);
      if (c == 2) exp_rdata = 64'h1122_3344_5566_7788;
      step();
    end
    req_i = 0; wb_m_ack_i = 0;
    exp_busy = 0; exp_stb = 0; exp_done = 1;
    step();
    exp_done = 0;
    chk("b2b_stb_cnt", 64'(obs_stb_cnt), 64'd3);
    step();

    // reset during a waiting access
    step();
    req_i = 1; addr_i = 64'h7000; size_i = 2'd2; we_i = 0;
    cyc_idx = 0; obs_done_at = -1;
    exp_busy = 1; exp_stb = 0; exp_addr = 64'h7000; exp_sel = 8'h0F; exp_dat = '0;
    step(); req_i = 0; exp_stb = 1;          // cycle 1
    step(); rst_i = 1;                       // cycle 2
    step(); rst_i = 0;                       // cycle 3
    exp_busy = 0; exp_stb = 0; exp_rdata = '0;
    step(); wb_m_ack_i = 1;                  // cycle 4: stray ack
    step(); wb_m_ack_i = 0;
    step();
    chk("rst_bus_no_done", 64'(obs_done_at), 64'hFFFF_FFFF_FFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
